alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one instance of the single-cycle `alu` among NUM_REQ requesters, for example the EX stage, branch-target and address-generation units in the upcoming multi-cycle core. It uses round-robin arbitration with a valid/ready handshake on the request side. The selected request is computed combinationally by the `alu`, then captured in a one-entry response register that has its own valid/ready handshake. It also flags opcodes the `alu` does not define.

Parameters:
NUM_REQ, 2, number of requesters (must be >= 2)
ID_W, $clog2(NUM_REQ), width of the requester index

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester request valid
i_req_op  in  4*NUM_REQ  packed alu_op; requester k uses bits [4k+3:4k]
i_req_a  in  32*NUM_REQ  packed operand_a; requester k uses [32k+31:32k]
i_req_b  in  32*NUM_REQ  packed operand_b, same packing
o_req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high
o_rsp_valid  out  1  response register holds a result
o_rsp_id  out  ID_W  index of the requester that owns the response
o_rsp_data  out  32  ALU result
o_rsp_err  out  1  opcode was illegal
i_rsp_ready  in  1  consumer accepts the response

Behaviour:
- Reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n. While reset is asserted:
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_rsp_err=0, o_req_ready=0.
  - The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
  - Reset in mid-transfer discards the response. There is no replay.
- Legal opcodes:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SRA 1101, LUI 1111.
  - Illegal opcodes: 1001, 1010, 1011, 1100, 1110.
- Accept condition: can_accept = !o_rsp_valid || i_rsp_ready.
- Grant selection:
  - Scan from ptr+1 upward, modulo NUM_REQ, and pick the first requester with its valid bit set.
  - o_req_ready[g] = can_accept && i_req_valid[g]. All other ready bits are 0.
  - Ready may depend combinationally on valid. Requesters must not make valid depend on ready.
- Handshake at the clock edge (valid & ready for requester g):
  - o_rsp_data <= alu result for op/a/b of g; forced to 0 if the opcode is illegal.
  - o_rsp_err <= illegal(op); o_rsp_id <= g; o_rsp_valid <= 1; ptr <= g.
- Latency and throughput:
  - Latency is 1 cycle from handshake to o_rsp_valid.
  - Throughput is 1 response per cycle while i_rsp_ready=1, with no bubble on a simultaneous drain and accept.
- Drain without a new accept: o_rsp_valid=1, i_rsp_ready=1 and no handshake gives o_rsp_valid <= 0. Data, id and err hold their last values.
- Backpressure: o_rsp_valid=1 and i_rsp_ready=0 gives all o_req_ready=0. Response fields stay stable. The pointer does not move.
- No valid requests: the pointer holds and there is no state change except the drain above.
- Requester obligations: once valid is asserted, hold op, a and b stable until ready. Operand changes before ready are allowed but only the accepted values matter.
- Fairness: with all requesters continuously valid and no backpressure, grants rotate 0,1,…,NUM_REQ-1,0,… Worst-case wait is NUM_REQ-1 grants, plus any backpressure stall.
- Arithmetic: exactly the `alu` semantics, 32-bit wrap-around. Shifts use b[4:0]. LUI passes b through.

Decomposition:
- Shared package alu_pkg contains:
  - 4-bit alu_op_e enum holding the 11 legal codes above.
  - Function is_legal_op(op).
  - Localparam ALU_W=32.
- The `alu` module is reused unchanged as the single sub-module, instantiated once.
- The round-robin pick stays inline as a priority scan from the pointer. It is not a separate module.

Test Plan:
- Reset mid-transfer: drive i_rst_n=0 while o_rsp_valid=1. All outputs go to 0 before the next edge. After release, req0 and req1 both valid gives req0 granted first.
- Single request: req1 ADD a=10 b=20. o_req_ready=2'b10 in the same cycle. Next cycle o_rsp_valid=1, id=1, data=30, err=0.
- Contention: req0 SUB 20-10 and req1 SRA a=0x80000000 b=1, both held valid, i_rsp_ready=1.
  - Expect responses id 0,1,0,1 on consecutive cycles.
  - Expect data 0x0000000A and 0xC0000000 respectively.
- Backpressure: hold i_rsp_ready=0 for 3 cycles with o_rsp_valid=1.
  - o_req_ready=0 throughout and the response is unchanged.
  - Raise i_rsp_ready: the next request is accepted the same cycle and the new response appears on the next cycle with no gap.
- Illegal opcode: req0 op 1010 gives err=1, data=0. Then SLTU a=1 b=0xFFFFFFFF gives err=0, data=1.
- LUI: op 1111 a=0 b=0xDEADBEEF gives data 0xDEADBEEF. Then SLT a=0xFFFFFFFF b=1 gives data=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encoding, response payload
// and the legal-opcode check used by the arbiter.
package alu_pkg;

  localparam int unsigned ALU_W = 32;
  localparam int unsigned OP_W  = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101,
    ALU_LUI  = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic             err;
    logic [ALU_W-1:0] data;
  } alu_rsp_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_OR, ALU_AND, ALU_SUB, ALU_SRA, ALU_LUI: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between NUM_REQ requesters, the shared-ALU arbiter
// and the response consumer. slave = arbiter side, master = client side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       i_req_valid;
  logic [OP_W*NUM_REQ-1:0]  i_req_op;
  logic [ALU_W*NUM_REQ-1:0] i_req_a;
  logic [ALU_W*NUM_REQ-1:0] i_req_b;
  logic [NUM_REQ-1:0]       o_req_ready;

  logic                     o_rsp_valid;
  logic [ID_W-1:0]          o_rsp_id;
  logic [ALU_W-1:0]         o_rsp_data;
  logic                     o_rsp_err;
  logic                     i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );

endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU; undefined opcodes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  output logic [ALU_W-1:0] o_result_c
);

  logic [4:0] shamt;
  assign shamt = i_b[4:0];

  always_comb begin
    o_result_c = '0;
    case (i_op)
      ALU_ADD:  o_result_c = i_a + i_b;
      ALU_SUB:  o_result_c = i_a - i_b;
      ALU_SLL:  o_result_c = i_a << shamt;
      ALU_SLT:  o_result_c = {{(ALU_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_result_c = {{(ALU_W-1){1'b0}}, i_a < i_b};
      ALU_XOR:  o_result_c = i_a ^ i_b;
      ALU_SRL:  o_result_c = i_a >> shamt;
      ALU_OR:   o_result_c = i_a | i_b;
      ALU_AND:  o_result_c = i_a & i_b;
      ALU_SRA:  o_result_c = $unsigned($signed(i_a) >>> shamt);
      ALU_LUI:  o_result_c = i_b;
      default:  o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, with a one-entry
// registered response stage that drains and refills in the same cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave bus
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  alu_rsp_t           rsp_q, rsp_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic               can_accept;
  logic               accept;
  logic [OP_W-1:0]    sel_op;
  logic [ALU_W-1:0]   sel_a, sel_b;
  logic [ALU_W-1:0]   alu_result;
  logic               sel_illegal;
  logic [NUM_REQ-1:0] req_ready_c;

  // Priority scan: first valid above the pointer, else first valid from 0 (wrap).
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!grant_found && bus.i_req_valid[i] && (i > int'(ptr_q))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!grant_found && bus.i_req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end

  // Steer the granted requester's operands into the shared ALU.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op = bus.i_req_op[i*OP_W +: OP_W];
        sel_a  = bus.i_req_a[i*ALU_W +: ALU_W];
        sel_b  = bus.i_req_b[i*ALU_W +: ALU_W];
      end
    end
  end

  alu u_alu (
    .i_op       (sel_op),
    .i_a        (sel_a),
    .i_b        (sel_b),
    .o_result_c (alu_result)
  );

  assign sel_illegal = !is_legal_op(sel_op);
  assign can_accept  = !rsp_valid_q || bus.i_rsp_ready;
  // Reset is folded in so no grant is offered while the block is held in reset.
  assign accept      = i_rst_n && can_accept && grant_found;

  always_comb begin
    req_ready_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready_c[i] = accept && (grant_id == ID_W'(i));
    end
  end

  // Next state: drain on consumer ready, overwrite on a new handshake.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (rsp_valid_q && bus.i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_id;
      rsp_d.err   = sel_illegal;
      rsp_d.data  = sel_illegal ? '0 : alu_result;
      ptr_d       = grant_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.o_req_ready = req_ready_c;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_data  = rsp_q.data;
  assign bus.o_rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares every consumed response.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_req_op[k*4 +: 4]  = op;
    bus.i_req_a[k*32 +: 32] = a;
    bus.i_req_b[k*32 +: 32] = b;
    bus.i_req_valid[k]      = 1'b1;
  endtask

  task automatic push(input int id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id   = ID_W'(id);
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // One request per cycle on requester 0, accepted at the next edge.
  task automatic vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] d, input logic err);
    issue(0, op, a, b);
    push(0, d, err);
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.o_rsp_valid), 64'd0);
    chk({tag, "_id"},    64'(bus.o_rsp_id),    64'd0);
    chk({tag, "_data"},  64'(bus.o_rsp_data),  64'd0);
    chk({tag, "_err"},   64'(bus.o_rsp_err),   64'd0);
    chk({tag, "_ready"}, 64'(bus.o_req_ready), 64'd0);
  endtask

  // Monitor: every consumed response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.o_rsp_valid && bus.i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0h with no expected entry",
                 bus.o_rsp_id, bus.o_rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id",   64'(bus.o_rsp_id),   64'(mon_e.id));
        chk("rsp_data", 64'(bus.o_rsp_data), 64'(mon_e.data));
        chk("rsp_err",  64'(bus.o_rsp_err),  64'(mon_e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_op    = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 1'b1;
    rst_n           = 1'b0;

    // Reset values, with requests pending that must not be granted.
    bus.i_req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    bus.i_req_valid = '0;
    tick();
    rst_n = 1'b1;

    // Single request on requester 1.
    issue(1, ALU_ADD, 32'd10, 32'd20);
    push(1, 32'd30, 1'b0);
    @(negedge clk);
    chk("single_ready", 64'(bus.o_req_ready), 64'b10);
    tick();
    bus.i_req_valid = '0;
    @(negedge clk);
    chk("single_latency", 64'(bus.o_rsp_valid), 64'd1);
    tick();

    // Contention: both valid, grants alternate starting at 0.
    issue(0, ALU_SUB, 32'd20, 32'd10);
    issue(1, ALU_SRA, 32'h8000_0000, 32'd1);
    for (int i = 0; i < 4; i++) begin
      push(i % 2, (i % 2 == 1) ? 32'hC000_0000 : 32'h0000_000A, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready", 64'(bus.o_req_ready), (i % 2 == 1) ? 64'b10 : 64'b01);
      if (i > 0) chk("rr_no_bubble", 64'(bus.o_rsp_valid), 64'd1);
      tick();
    end
    bus.i_req_valid = '0;

    // Backpressure: held response (id 1, SRA) must stay put, no grants.
    bus.i_rsp_ready = 1'b0;
    issue(0, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    push(0, 32'hF000_F000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.o_req_ready), 64'd0);
      chk("bp_valid", 64'(bus.o_rsp_valid), 64'd1);
      chk("bp_id",    64'(bus.o_rsp_id),    64'd1);
      chk("bp_data",  64'(bus.o_rsp_data),  64'hC000_0000);
      tick();
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(bus.o_req_ready), 64'b01);
    tick();
    bus.i_req_valid = '0;
    @(negedge clk);
    chk("bp_release_valid", 64'(bus.o_rsp_valid), 64'd1);
    tick();

    // Illegal opcode followed by SLTU back-to-back.
    vec(4'b1010, 32'd5, 32'd7, 32'd0, 1'b1);
    vec(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Remaining operations, wrap-around and the other illegal codes.
    vec(ALU_SLL,  32'd1,         32'h21,        32'd2,         1'b0);
    vec(ALU_SRL,  32'h8000_0000, 32'd31,        32'd1,         1'b0);
    vec(ALU_SRA,  32'h7FFF_FFFF, 32'h24,        32'h07FF_FFFF, 1'b0);
    vec(ALU_XOR,  32'hFF00,      32'h0FF0,      32'hF0F0,      1'b0);
    vec(ALU_OR,   32'hF0,        32'h0F,        32'hFF,        1'b0);
    vec(ALU_ADD,  32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0);
    vec(ALU_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0);
    vec(ALU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);
    vec(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    vec(4'b1001,  32'd3,         32'd4,         32'd0,         1'b1);
    vec(4'b1011,  32'd3,         32'd4,         32'd0,         1'b1);
    vec(4'b1100,  32'd3,         32'd4,         32'd0,         1'b1);
    vec(4'b1110,  32'd3,         32'd4,         32'd0,         1'b1);
    bus.i_req_valid = '0;
    tick();

    // LUI then signed compare on requester 1.
    issue(1, ALU_LUI, 32'd0, 32'hDEAD_BEEF);
    push(1, 32'hDEAD_BEEF, 1'b0);
    tick();
    issue(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    push(1, 32'd1, 1'b0);
    tick();
    bus.i_req_valid = '0;
    tick();

    // Reset while a response is held: everything clears before the next edge.
    issue(0, ALU_ADD, 32'd1, 32'd1);
    tick();
    bus.i_req_valid = '0;
    bus.i_rsp_ready = 1'b0;
    #1;
    chk("mid_valid_before_rst", 64'(bus.o_rsp_valid), 64'd1);
    rst_n = 1'b0;
    bus.i_req_valid = 2'b11;
    #1;
    chk_idle("mid_rst");

    // After release, requester 0 wins first, then 1.
    issue(0, ALU_ADD, 32'd3, 32'd4);
    issue(1, ALU_ADD, 32'd5, 32'd6);
    tick();
    tick();
    rst_n = 1'b1;
    bus.i_rsp_ready = 1'b1;
    push(0, 32'd7, 1'b0);
    push(1, 32'd11, 1'b0);
    @(negedge clk);
    chk("post_rst_ready0", 64'(bus.o_req_ready), 64'b01);
    tick();
    @(negedge clk);
    chk("post_rst_ready1", 64'(bus.o_req_ready), 64'b10);
    tick();
    bus.i_req_valid = '0;
    tick();
    tick();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
